// File: rtl/vote_logger.sv
// -----------------------------------------------------------------------------
// vote_logger
//
// Voting-side front end of the EVM. In voting mode it samples the four
// candidate buttons and accepts at most one vote per press. It keeps four
// saturating 8-bit tallies. Each accepted vote produces a one-cycle
// valid_vote_casted strobe. Each rejected press (several buttons at once, or
// a press on a saturated tally) produces a one-cycle invalid_vote strobe. No
// votes are accepted while mode selects result mode.
//
// Configuration macro: VOTE_LOGGER_LOCKOUT_EN
//   defined   : after an accepted vote, every button is ignored for
//               LOCKOUT_CYCLES cycles before the release wait.
//   undefined : an accepted vote goes straight to the release wait, and
//               LOCKOUT_CYCLES only takes part in the legality check.
//
// Parameters
//   LOCKOUT_CYCLES           lockout length in cycles, legal range 1..255
//
// Ports
//   clock                    system clock, rising edge
//   reset                    synchronous active-high reset
//   mode                     0 = voting, 1 = result (buttons ignored)
//   candidateN_button_press  synchronised, debounced button levels (N = 1..4)
//   candidateN_vote          registered 8-bit tallies (N = 1..4)
//   valid_vote_casted        registered one-cycle pulse per accepted vote
//   invalid_vote             registered one-cycle pulse per rejected press
// -----------------------------------------------------------------------------
module vote_logger #(
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mode,
    input  logic       candidate1_button_press,
    input  logic       candidate2_button_press,
    input  logic       candidate3_button_press,
    input  logic       candidate4_button_press,
    output logic [7:0] candidate1_vote,
    output logic [7:0] candidate2_vote,
    output logic [7:0] candidate3_vote,
    output logic [7:0] candidate4_vote,
    output logic       valid_vote_casted,
    output logic       invalid_vote
);

    typedef enum logic [1:0] {
        ST_READY        = 2'd0,
`ifdef VOTE_LOGGER_LOCKOUT_EN
        ST_LOCKOUT      = 2'd1,
`endif
        ST_WAIT_RELEASE = 2'd2
    } state_t;

    // Reject an out-of-range lockout length when the design is elaborated.
    if ((LOCKOUT_CYCLES < 1) || (LOCKOUT_CYCLES > 255)) begin : g_bad_lockout
        $error("vote_logger: LOCKOUT_CYCLES must be within 1..255");
    end

    logic [3:0]      btn_s;
    logic [1:0]      sel_s;
    logic            single_s;

    state_t          state_q, state_d;
    logic [3:0][7:0] tally_q, tally_d;
    logic            valid_q, valid_d;
    logic            invalid_q, invalid_d;

`ifdef VOTE_LOGGER_LOCKOUT_EN
    localparam logic [7:0] LOCKOUT_LOAD = 8'(LOCKOUT_CYCLES);
    logic [7:0]      cnt_q, cnt_d;
`endif

    assign btn_s = {candidate4_button_press, candidate3_button_press,
                    candidate2_button_press, candidate1_button_press};

    // Decode the button vector. It is either exactly one press with its
    // index, or not a single press at all.
    always_comb begin
        sel_s    = 2'd0;
        single_s = 1'b0;
        case (btn_s)
            4'b0001: begin sel_s = 2'd0; single_s = 1'b1; end
            4'b0010: begin sel_s = 2'd1; single_s = 1'b1; end
            4'b0100: begin sel_s = 2'd2; single_s = 1'b1; end
            4'b1000: begin sel_s = 2'd3; single_s = 1'b1; end
            default: begin sel_s = 2'd0; single_s = 1'b0; end
        endcase
    end

    // Compute the next state, the tally update and the strobe values.
    always_comb begin
        state_d   = state_q;
        tally_d   = tally_q;
        valid_d   = 1'b0;
        invalid_d = 1'b0;
`ifdef VOTE_LOGGER_LOCKOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            ST_READY: begin
                if (!mode && (btn_s != 4'b0000)) begin
                    if (single_s && (tally_q[sel_s] != 8'hFF)) begin
                        tally_d[sel_s] = tally_q[sel_s] + 8'd1;
                        valid_d        = 1'b1;
`ifdef VOTE_LOGGER_LOCKOUT_EN
                        state_d        = ST_LOCKOUT;
                        cnt_d          = LOCKOUT_LOAD;
`else
                        state_d        = ST_WAIT_RELEASE;
`endif
                    end else begin
                        // Multiple presses or a saturated tally: reject and
                        // wait for a full release so the press cannot retry.
                        invalid_d = 1'b1;
                        state_d   = ST_WAIT_RELEASE;
                    end
                end else begin
                    state_d = ST_READY;
                end
            end
`ifdef VOTE_LOGGER_LOCKOUT_EN
            ST_LOCKOUT: begin
                // The counter is loaded with N on entry. The exit happens at
                // the Nth following edge, so the state is held for exactly N
                // cycles.
                if (cnt_q <= 8'd1) begin
                    cnt_d   = 8'd0;
                    state_d = ST_WAIT_RELEASE;
                end else begin
                    cnt_d   = cnt_q - 8'd1;
                    state_d = ST_LOCKOUT;
                end
            end
`endif
            ST_WAIT_RELEASE: begin
                if (btn_s == 4'b0000) begin
                    state_d = ST_READY;
                end else begin
                    state_d = ST_WAIT_RELEASE;
                end
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

    // State, tally and strobe registers. Reset overrides a press on the
    // same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_READY;
            tally_q   <= {4{8'h00}};
            valid_q   <= 1'b0;
            invalid_q <= 1'b0;
`ifdef VOTE_LOGGER_LOCKOUT_EN
            cnt_q     <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            tally_q   <= tally_d;
            valid_q   <= valid_d;
            invalid_q <= invalid_d;
`ifdef VOTE_LOGGER_LOCKOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign candidate1_vote   = tally_q[0];
    assign candidate2_vote   = tally_q[1];
    assign candidate3_vote   = tally_q[2];
    assign candidate4_vote   = tally_q[3];
    assign valid_vote_casted = valid_q;
    assign invalid_vote      = invalid_q;

endmodule

// File: tb/tb_vote_logger.sv
// -----------------------------------------------------------------------------
// tb_vote_logger
//
// Directed testbench for vote_logger. The expected tallies and pulse counts
// are computed by hand. The expectations depend on VOTE_LOGGER_LOCKOUT_EN,
// which sets the lockout length to 16 cycles or to zero. Inputs change on
// the falling edge, and outputs are compared on the falling edge.
// -----------------------------------------------------------------------------
module tb_vote_logger;

`ifdef VOTE_LOGGER_LOCKOUT_EN
    localparam int LOCK = 16;
`else
    localparam int LOCK = 0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       mode;
    logic [3:0] btn;
    logic [7:0] c1, c2, c3, c4;
    logic       valid, invalid;

    int checks  = 0;
    int errors  = 0;
    int vcnt    = 0;
    int icnt    = 0;
    int overlap = 0;
    int v0, i0;
    int exp_c1;

    vote_logger #(.LOCKOUT_CYCLES(16)) dut (
        .clock                   (clock),
        .reset                   (reset),
        .mode                    (mode),
        .candidate1_button_press (btn[0]),
        .candidate2_button_press (btn[1]),
        .candidate3_button_press (btn[2]),
        .candidate4_button_press (btn[3]),
        .candidate1_vote         (c1),
        .candidate2_vote         (c2),
        .candidate3_vote         (c3),
        .candidate4_vote         (c4),
        .valid_vote_casted       (valid),
        .invalid_vote            (invalid)
    );

    always #5 clock = ~clock;

    // Count the strobes, and count any cycle in which both strobes are high.
    always @(posedge clock) begin
        if (valid)   vcnt <= vcnt + 1;
        if (invalid) icnt <= icnt + 1;
        if (valid && invalid) overlap <= overlap + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        reset = 1'b1;
        mode  = 1'b0;
        btn   = 4'b0000;
        tick(2);
        check("rst_c1", c1, 0);
        check("rst_c2", c2, 0);
        check("rst_c3", c3, 0);
        check("rst_c4", c4, 0);
        check("rst_valid", valid, 0);
        check("rst_invalid", invalid, 0);
        reset = 1'b0;
        tick(1);

        // Hold candidate 2 for 50 cycles: exactly one vote.
        v0 = vcnt; i0 = icnt;
        btn = 4'b0010;
        tick(1);
        check("lat_valid", valid, 1);
        check("lat_c2", c2, 1);
        tick(1);
        check("pulse_width", valid, 0);
        tick(48);
        btn = 4'b0000;
        tick(LOCK + 3);
        check("hold_c2", c2, 1);
        check("hold_vcnt", vcnt - v0, 1);
        check("hold_icnt", icnt - i0, 0);
        check("hold_c1", c1, 0);
        check("hold_c3", c3, 0);
        check("hold_c4", c4, 0);

        // Candidate 1: release at cycle 3, re-press at cycle 5.
        v0 = vcnt;
        btn = 4'b0001; tick(3);
        btn = 4'b0000; tick(2);
        btn = 4'b0001; tick(3);
        btn = 4'b0000; tick(LOCK + 3);
        exp_c1 = (LOCK > 0) ? 1 : 2;
        check("repress_c1", c1, exp_c1);
        btn = 4'b0001; tick(1);
        btn = 4'b0000; tick(LOCK + 3);
        exp_c1++;
        check("late_c1", c1, exp_c1);
        check("repress_vcnt", vcnt - v0, exp_c1);

        // Candidates 3 and 4 pressed together: rejected until both released.
        v0 = vcnt; i0 = icnt;
        btn = 4'b1100; tick(1);
        check("multi_invalid", invalid, 1);
        check("multi_valid", valid, 0);
        tick(4);
        btn = 4'b0100; tick(3);
        check("multi_c3", c3, 0);
        check("multi_c4", c4, 0);
        btn = 4'b0000; tick(2);
        btn = 4'b0100; tick(1);
        check("after_rel_valid", valid, 1);
        check("after_rel_c3", c3, 1);
        btn = 4'b0000; tick(LOCK + 3);
        check("multi_icnt", icnt - i0, 1);
        check("multi_vcnt", vcnt - v0, 1);

        // Strobe spacing: one cycle too early is refused, the minimum is accepted.
        v0 = vcnt;
        btn = 4'b0001; tick(1);
        check("space_first", valid, 1);
        btn = 4'b0000; tick(LOCK);
        btn = 4'b0001; tick(1);
        check("space_early", valid, 0);
        btn = 4'b0000; tick(1);
        btn = 4'b0001; tick(1);
        check("space_a", valid, 1);
        btn = 4'b0000; tick(LOCK + 1);
        btn = 4'b0001; tick(1);
        check("space_min", valid, 1);
        btn = 4'b0000; tick(LOCK + 3);
        exp_c1 += 3;
        check("space_c1", c1, exp_c1);
        check("space_vcnt", vcnt - v0, 3);

        // Saturate candidate 4 at 255, then press once more.
        v0 = vcnt;
        for (int k = 0; k < 255; k++) begin
            btn = 4'b1000; tick(1);
            btn = 4'b0000; tick(LOCK + 2);
        end
        tick(2);
        check("sat_c4", c4, 255);
        check("sat_vcnt", vcnt - v0, 255);
        btn = 4'b1000; tick(1);
        check("sat_hold", c4, 255);
        check("sat_invalid", invalid, 1);
        check("sat_valid", valid, 0);
        btn = 4'b0000; tick(LOCK + 3);

        // Result mode: all presses are ignored.
        v0 = vcnt; i0 = icnt;
        mode = 1'b1;
        for (int k = 0; k < 4; k++) begin
            btn = 4'b0001 << k; tick(2);
            btn = 4'b0000; tick(2);
        end
        check("mode_c1", c1, exp_c1);
        check("mode_c2", c2, 1);
        check("mode_c3", c3, 1);
        check("mode_c4", c4, 255);
        check("mode_vcnt", vcnt - v0, 0);
        check("mode_icnt", icnt - i0, 0);
        mode = 1'b0;
        btn = 4'b0001; tick(1);
        exp_c1++;
        check("mode_back_c1", c1, exp_c1);
        btn = 4'b0000; tick(LOCK + 3);

        // Reset arrives together with a press, and the button stays held.
        btn = 4'b0010; reset = 1'b1; tick(1);
        check("rstp_c1", c1, 0);
        check("rstp_c2", c2, 0);
        check("rstp_c3", c3, 0);
        check("rstp_c4", c4, 0);
        check("rstp_valid", valid, 0);
        reset = 1'b0; tick(1);
        check("rstp_ready", valid, 1);
        check("rstp_c2_after", c2, 1);
        btn = 4'b0000; tick(LOCK + 3);

        check("no_overlap", overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
